// File: rtl/instr_fetch_issue_pkg.sv
// Shared definitions for the instruction fetch/issue slice: ARM field
// positions, condition/opcode encodings, fetch FSM states and defaults.
package instr_fetch_issue_pkg;

    localparam int INSTR_W = 32;

    // Bit positions of the ARM-style fields inside a 32-bit instruction word.
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RN_MSB    = 19;
    localparam int RN_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;
    localparam int IMM_MSB   = 23;
    localparam int IMM_LSB   = 0;

    // Default byte increment between sequential instructions.
    localparam int DEFAULT_PC_STEP = 4;

    // Condition codes understood by the decoder.
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_AL = 4'b1110
    } cond_e;

    // Major opcode classes.
    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // offering a request to instruction memory
        ST_WAIT = 2'd1,  // request accepted, waiting for the word
        ST_HOLD = 2'd2,  // word buffered and offered to the decoder
        ST_DROP = 2'd3   // redirect happened with a response in flight
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_issue_field_split.sv
// Combinational slicer that breaks a 32-bit instruction word into the
// ARM-style fields consumed by the control decoder. Also usable by a
// trace monitor, so it carries no state of its own.
module instr_field_split
    import instr_fetch_issue_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic [3:0]         cond_o,
    output logic [1:0]         op_o,
    output logic [5:0]         funct_o,
    output logic [3:0]         rn_o,
    output logic [3:0]         rd_o,
    output logic [23:0]        imm24_o
);

    // Pure wiring: every field is a fixed slice of the word; Imm24 overlaps
    // Funct/Rn/Rd on purpose, the decoder chooses which view it uses.
    assign cond_o  = instr_i[COND_MSB:COND_LSB];
    assign op_o    = instr_i[OP_MSB:OP_LSB];
    assign funct_o = instr_i[FUNCT_MSB:FUNCT_LSB];
    assign rn_o    = instr_i[RN_MSB:RN_LSB];
    assign rd_o    = instr_i[RD_MSB:RD_LSB];
    assign imm24_o = instr_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue stage: owns the PC, fetches one instruction at a time over a
// valid/ready request channel, buffers it and presents it to the decoder as
// split fields. Applies the decoder's PCSrc redirect and owns the Z flag.
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEFAULT_PC_STEP,
    // Test hook: when set, PCSrc is also honoured while a fetch is
    // outstanding; the in-flight word is then discarded via DROP.
    parameter bit                REDIRECT_IN_WAIT = 1'b0
)(
    input  logic              clk,
    input  logic              rst_n,
    // Instruction memory request/response
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    // Issue toward the decoder
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [3:0]        Cond,
    output logic [1:0]        Op,
    output logic [5:0]        Funct,
    output logic [3:0]        Rd,
    output logic [3:0]        Rn,
    output logic [23:0]       Imm24,
    output logic [ADDR_W-1:0] issue_pc,
    // Redirect from the decoder
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] branch_target,
    // Z flag
    input  logic              flag_we,
    input  logic              alu_zero,
    output logic              ZeroFlags
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              z_q, z_d;

    logic              req_fire;
    logic              issue_fire;
    logic              wait_redirect;

    // A request only counts once it is actually being offered; this keeps the
    // first post-reset cycle (state already REQ, valid still low) inert.
    assign req_fire      = req_valid_q && imem_req_ready;
    assign issue_fire    = (state_q == ST_HOLD) && issue_ready;
    assign wait_redirect = REDIRECT_IN_WAIT && (state_q == ST_WAIT) && PCSrc;

    // Next-state, PC and buffer update logic for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        unique case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_redirect) begin
                    // The outstanding word belongs to the abandoned path. If it
                    // is arriving right now it is simply not latched; otherwise
                    // wait for it in DROP.
                    pc_d    = branch_target;
                    state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    ipc_d   = pc_q;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (issue_fire) begin
                    // PCSrc is only meaningful alongside a consumed issue.
                    pc_d    = PCSrc ? branch_target : (pc_q + STEP);
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Z flag follows alu_zero whenever a flag-setting op retires.
    always_comb begin
        z_d = z_q;
        if (flag_we) begin
            z_d = alu_zero;
        end
    end

    // State, PC, instruction buffer and request-valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            instr_q     <= '0;
            ipc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= (state_d == ST_REQ);
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
        end
    end

    // Z flag register, independent of the fetch FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign issue_valid    = (state_q == ST_HOLD);
    assign issue_pc       = ipc_q;
    assign ZeroFlags      = z_q;

    instr_field_split u_field_split (
        .instr_i (instr_q),
        .cond_o  (Cond),
        .op_o    (Op),
        .funct_o (Funct),
        .rn_o    (Rn),
        .rd_o    (Rd),
        .imm24_o (Imm24)
    );

    // Handshake stability: an offered request or issued instruction may not
    // change until it is taken.
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_addr)));

    a_issue_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (issue_valid && !issue_ready) |=> (issue_valid && $stable(issue_pc)));

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios plus a
// randomized run, all judged against a transaction-level model of the
// fetch/issue contract kept in this file.
module tb_instr_fetch_issue;
    import instr_fetch_issue_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [3:0]  Rn;
    logic [23:0] Imm24;
    logic [31:0] issue_pc;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        flag_we;
    logic        alu_zero;
    logic        ZeroFlags;

    always #5 clk = ~clk;

    instr_fetch_issue #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .Cond           (Cond),
        .Op             (Op),
        .Funct          (Funct),
        .Rd             (Rd),
        .Rn             (Rn),
        .Imm24          (Imm24),
        .issue_pc       (issue_pc),
        .PCSrc          (PCSrc),
        .branch_target  (branch_target),
        .flag_we        (flag_we),
        .alu_zero       (alu_zero),
        .ZeroFlags      (ZeroFlags)
    );

    int checks = 0;
    int errors = 0;

    // Instruction memory image, indexed by word address bits [7:2].
    logic [31:0] img [0:63];

    // Stimulus knobs
    int          rdy_pct;
    int          iss_pct;
    int          br_pct;
    int          fwe_pct;
    int          mem_max_delay;
    bit          force_br;
    logic [31:0] force_tgt;
    bit          flag_manual;
    bit          fwe_val;
    bit          fz_val;

    // Reference model: PC of the next fetch, one outstanding fetch at most,
    // one held instruction at most, and the Z flag.
    logic [31:0] m_pc;
    logic [31:0] m_inflight;
    logic [31:0] m_held_pc;
    bit          m_out;
    bit          m_held;
    bit          m_started;
    bit          m_z;
    int          m_delay;
    logic [31:0] req_log [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return img[a[7:2]];
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_out     = 1'b0;
        m_held    = 1'b0;
        m_started = 1'b0;
        m_z       = 1'b0;
        m_delay   = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        issue_ready    = 1'b0;
        PCSrc          = 1'b0;
        branch_target  = '0;
        flag_we        = 1'b0;
        alu_zero       = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock,
    // then advance the model by the transactions that took place.
    task automatic tick();
        bit          exp_req;
        bit          req_fire;
        bit          rsp_fire;
        bit          iss_fire;
        bit          br;
        bit          fwe;
        bit          fz;
        logic [31:0] tgt;
        logic [31:0] w;

        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        issue_ready    = (int'($urandom_range(99)) < iss_pct);
        if (force_br) begin
            PCSrc         = 1'b1;
            branch_target = force_tgt;
        end else begin
            PCSrc         = (int'($urandom_range(99)) < br_pct);
            branch_target = $urandom() & 32'hFFFF_FFFC;
        end
        if (flag_manual) begin
            flag_we  = fwe_val;
            alu_zero = fz_val;
        end else begin
            flag_we  = (int'($urandom_range(99)) < fwe_pct);
            alu_zero = 1'($urandom_range(1));
        end
        if (m_out && m_delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(m_inflight);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
            if (m_out) m_delay--;
        end

        exp_req = m_started && !m_out && !m_held;
        checks++;
        if (imem_req_valid !== exp_req) begin
            errors++;
            $display("FAIL req_valid got=%b exp=%b t=%0t", imem_req_valid, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== m_pc) begin
                errors++;
                $display("FAIL imem_addr got=%h exp=%h t=%0t", imem_addr, m_pc, $time);
            end
        end
        checks++;
        if (issue_valid !== m_held) begin
            errors++;
            $display("FAIL issue_valid got=%b exp=%b t=%0t", issue_valid, m_held, $time);
        end
        if (m_held) begin
            w = word_of(m_held_pc);
            checks++;
            if (issue_pc !== m_held_pc) begin
                errors++;
                $display("FAIL issue_pc got=%h exp=%h t=%0t", issue_pc, m_held_pc, $time);
            end
            checks++;
            if ({Cond, Op, Funct, Rn, Rd, Imm24} !==
                {w[31:28], w[27:26], w[25:20], w[19:16], w[15:12], w[23:0]}) begin
                errors++;
                $display("FAIL fields got=%h/%h/%h/%h/%h/%h word=%h t=%0t",
                         Cond, Op, Funct, Rn, Rd, Imm24, w, $time);
            end
        end
        checks++;
        if (ZeroFlags !== m_z) begin
            errors++;
            $display("FAIL zero_flag got=%b exp=%b t=%0t", ZeroFlags, m_z, $time);
        end

        req_fire = exp_req && imem_req_ready;
        rsp_fire = m_out && imem_rsp_valid;
        iss_fire = m_held && issue_ready;
        br       = PCSrc;
        tgt      = branch_target;
        fwe      = flag_we;
        fz       = alu_zero;

        @(posedge clk);
        #1;

        if (fwe) m_z = fz;
        if (iss_fire) begin
            m_pc   = br ? tgt : (m_held_pc + 32'd4);
            m_held = 1'b0;
        end
        if (rsp_fire) begin
            m_out     = 1'b0;
            m_held    = 1'b1;
            m_held_pc = m_inflight;
        end
        if (req_fire) begin
            m_out      = 1'b1;
            m_inflight = m_pc;
            m_delay    = int'($urandom_range(mem_max_delay));
            req_log.push_back(m_pc);
        end
        m_started = 1'b1;
    endtask

    task automatic run_until_held(input int limit, input string tag);
        int n;
        n = 0;
        while (!m_held && n < limit) begin
            tick();
            n++;
        end
        if (!m_held) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got=no_issue exp=issue within %0d cycles", tag, limit);
        end
    endtask

    task automatic set_knobs(input int rdy, input int iss, input int brp, input int dly);
        rdy_pct       = rdy;
        iss_pct       = iss;
        br_pct        = brp;
        mem_max_delay = dly;
        force_br      = 1'b0;
        flag_manual   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        set_knobs(100, 0, 0, 1);
        flag_manual = 1'b1;
        fwe_val     = 1'b1;
        fz_val      = 1'b1;
        run_until_held(20, "reset_pre");
        tick();
        // Busy state with Z=1 and a held instruction; now reset.
        do_reset(1);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
        end
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue_valid got=%b exp=0", issue_valid);
        end
        checks++;
        if (ZeroFlags !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero got=%b exp=0", ZeroFlags);
        end
        checks++;
        if ({Cond, Op, Funct, Rn, Rd, Imm24, issue_pc} !== '0) begin
            errors++;
            $display("FAIL reset_fields got=%h/%h/%h/%h/%h/%h pc=%h exp=0",
                     Cond, Op, Funct, Rn, Rd, Imm24, issue_pc);
        end
        flag_manual = 1'b0;
        fwe_pct     = 0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, RESET_PC);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset(1);
        set_knobs(100, 100, 0, 0);
        fwe_pct = 0;
        req_log.delete();
        run_until_held(10, "basic");
        checks++;
        if (Cond !== COND_AL || Op !== OP_DP || Funct !== 6'b101000 ||
            Rn !== 4'b0001 || Rd !== 4'b0001 || issue_pc !== 32'h0) begin
            errors++;
            $display("FAIL basic_decode got=%b/%b/%b/%b/%b pc=%h exp=1110/00/101000/0001/0001 pc=0",
                     Cond, Op, Funct, Rn, Rd, issue_pc);
        end
        repeat (10) tick();
        checks++;
        if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL basic_addr_seq got=%0d reqs first=%h exp=0,4,8",
                     req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hx);
        end
        $display("test_basic done reqs=%0d", req_log.size());
    endtask

    task automatic test_stall();
        int cnt;
        do_reset(1);
        set_knobs(0, 100, 0, 2);
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req_valid === 1'b1 && imem_addr === RESET_PC) cnt++;
            if (i == 3) rdy_pct = 100;
            tick();
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL stall_req_held got=%0d cycles exp=4", cnt);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_drop got=%b exp=0", imem_req_valid);
        end
        $display("test_stall done");
    endtask

    task automatic test_hold();
        logic [31:0] pc_s;
        logic [43:0] f_s;
        bit          stable;
        iss_pct = 0;
        run_until_held(20, "hold");
        pc_s   = issue_pc;
        f_s    = {Cond, Op, Funct, Rn, Rd, Imm24};
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (issue_pc !== pc_s || {Cond, Op, Funct, Rn, Rd, Imm24} !== f_s ||
                imem_req_valid !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL hold_stable got=changed exp=stable pc=%h", pc_s);
        end
        iss_pct = 100;
        br_pct  = 0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== pc_s + 32'd4) begin
            errors++;
            $display("FAIL hold_advance got=%b/%h exp=1/%h", imem_req_valid, imem_addr, pc_s + 32'd4);
        end
        $display("test_hold done pc=%h", pc_s);
    endtask

    task automatic test_redirect();
        int n;
        do_reset(1);
        set_knobs(100, 100, 0, 0);
        n = 0;
        while (!(m_held && m_held_pc == 32'h10) && n < 100) begin
            tick();
            n++;
        end
        force_br  = 1'b1;
        force_tgt = 32'h40;
        tick();
        force_br = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redirect_addr got=%b/%h exp=1/00000040", imem_req_valid, imem_addr);
        end
        $display("test_redirect done");
    endtask

    task automatic test_wrap();
        set_knobs(100, 100, 0, 1);
        run_until_held(20, "wrap_a");
        force_br  = 1'b1;
        force_tgt = 32'hFFFF_FFFC;
        tick();
        force_br = 1'b0;
        run_until_held(20, "wrap_b");
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got=%b/%h exp=1/00000000", imem_req_valid, imem_addr);
        end
        $display("test_wrap done");
    endtask

    task automatic test_flags();
        bit we_v [3] = '{1'b1, 1'b0, 1'b1};
        bit z_v  [3] = '{1'b1, 1'b0, 1'b0};
        bit exp_v[3] = '{1'b1, 1'b1, 1'b0};
        set_knobs(50, 50, 20, 2);
        flag_manual = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwe_val = we_v[i];
            fz_val  = z_v[i];
            tick();
            checks++;
            if (ZeroFlags !== exp_v[i]) begin
                errors++;
                $display("FAIL flag_step%0d got=%b exp=%b", i, ZeroFlags, exp_v[i]);
            end
        end
        flag_manual = 1'b0;
        $display("test_flags done");
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(1);
        set_knobs(100, 100, 0, 0);
        fwe_pct = 100;
        n = 0;
        while (!m_out && n < 10) begin
            tick();
            n++;
        end
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        issue_ready    = 1'b0;
        flag_we        = 1'b1;
        alu_zero       = 1'b1;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        flag_we        = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC || issue_valid !== 1'b0 ||
            ZeroFlags !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state got=%b/%h/%b/%b exp=1/%h/0/0",
                     imem_req_valid, imem_addr, issue_valid, ZeroFlags, RESET_PC);
        end
        @(posedge clk);
        #1;
        checks++;
        if (issue_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stale got=%b/%b exp=0/1", issue_valid, imem_req_valid);
        end
        model_reset();
        m_started = 1'b1;
        fwe_pct   = 30;
        repeat (20) tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        do_reset(1);
        fwe_pct = 30;
        for (int ph = 0; ph < 6; ph++) begin
            set_knobs(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
            repeat (500) tick();
            $display("test_random phase %0d rdy=%0d iss=%0d br=%0d dly=%0d reqs=%0d",
                     ph, rdy_pct, iss_pct, br_pct, mem_max_delay, req_log.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) img[i] = $urandom();
        img[0]  = 32'hE281_1001;
        fwe_pct = 0;
        set_knobs(100, 100, 0, 0);
        fwe_val   = 1'b0;
        fz_val    = 1'b0;
        force_tgt = '0;
        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_redirect();
        test_wrap();
        test_flags();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
Fetch-side counterpart of the single-cycle control decoder. It owns the PC and requests instruction words from instruction memory over a valid/ready handshake. It buffers one word and issues it to the decoder as split ARM-style fields (Cond, Op, Funct, Rd, Rn, Imm24). It consumes the decoder's PCSrc redirect and owns the Z flag register that drives the decoder's ZeroFlags input.

Parameters:
ADDR_W, 32, PC / memory address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential instruction

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  ADDR_W  fetch address (= PC while request pending)
imem_rsp_valid  input  1  instruction word returned (one response per accepted request, in order)
imem_rsp_data  input  32  instruction word
issue_valid  output  1  buffered instruction valid toward decoder
issue_ready  input  1  decoder/datapath consumes instruction this cycle
Cond  output  4  instr[31:28]
Op  output  2  instr[27:26]
Funct  output  6  instr[25:20]
Rd  output  4  instr[15:12]
Rn  output  4  instr[19:16]
Imm24  output  24  instr[23:0]
issue_pc  output  ADDR_W  PC of issued instruction
PCSrc  input  1  redirect request from control decoder
branch_target  input  ADDR_W  redirect address, sampled when PCSrc=1
flag_we  input  1  update Z flag (CMP/flag-setting op retiring)
alu_zero  input  1  ALU zero result
ZeroFlags  output  1  registered Z flag

Behaviour:
- Reset (rst_n=0 at clk edge): PC=RESET_PC, state=REQ, ZeroFlags=0, issue_valid=0, imem_req_valid=0, all field outputs and issue_pc=0, drop flag=0.
- FSM states:
  - REQ: imem_req_valid=1, imem_addr=PC. On imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, latch word and PC into the buffer -> HOLD.
  - HOLD: issue_valid=1, fields driven combinationally from the buffer. On issue_ready: PC=PC+PC_STEP (mod 2^ADDR_W) -> REQ.
  - DROP: waits for the stale response, discards it -> REQ.
- imem_req_valid is a registered view of state==REQ. It is first high in the first cycle after rst_n deasserts. It stays high, with stable address, until ready.
- Minimum latency: request accepted in cycle N, response in N+1, issue_valid in N+2.
- Redirect: PCSrc=1 with issue_valid && issue_ready. PCSrc is ignored in all other cycles.
  - PC=branch_target, not PC+PC_STEP, then next state REQ.
- Redirect in WAIT (outstanding request) cannot occur under the rule above; the DROP path exists for robustness.
  - If PCSrc is asserted with a forced-valid test hook in WAIT, PC=target and the next response is discarded.
- issue_ready without issue_valid has no effect.
- Z flag: ZeroFlags<=alu_zero when flag_we=1, else hold. Updates independently of FSM state.
  - A simultaneous flag_we and redirect performs both updates.
- Wrap-around: PC at max word address plus step wraps to 0 with no error.
- Reset mid-operation: any in-flight request is abandoned. Memory must also be reset, or a late rsp must be tolerated: rsp_valid outside WAIT/DROP is ignored.
- Buffer holds exactly one instruction. No new request is issued until the held instruction is consumed (no prefetch).

Decomposition:
- Shared package holds:
  - ARM field bit positions.
  - Cond codes: EQ=4'b0000, NE=4'b0001, AL=4'b1110.
  - Op encodings: DP=2'b00, MEM=2'b01, BR=2'b10.
  - FSM state enum: REQ/WAIT/HOLD/DROP.
  - PC_STEP default.
- One natural sub-module: instr_field_split, a combinational slicer from 32-bit word to Cond/Op/Funct/Rd/Rn/Imm24. It is reused by the trace monitor.

Test Plan:
- Reset, then single-cycle memory, issue_ready=1: addresses 0x0,0x4,0x8 requested. Word 0xE2811001 issues Cond=1110, Op=00, Funct=101000, Rn=0001, Rd=0001.
- Memory stalls imem_req_ready low 3 cycles: imem_req_valid=1 with addr stable for 4 cycles. No issue_valid until response.
- Decoder holds issue_ready=0 for 5 cycles in HOLD: fields and issue_pc stable, no new request. Release, then PC advances by 4.
- Issue at PC=0x10 with PCSrc=1, branch_target=0x40: next imem_addr=0x40, not 0x14.
- flag_we=1, alu_zero=1: ZeroFlags=1 next cycle. flag_we=0, alu_zero=0: ZeroFlags stays 1. flag_we=1, alu_zero=0: ZeroFlags=0.
- rst_n low during WAIT with rsp arriving next cycle: response ignored. Post-reset first imem_addr=RESET_PC, ZeroFlags=0, issue_valid=0.
